// File: rtl/fp_pkg.sv
// fp_pkg: shared FP types, state encoding and constants for the FP issue/collect path.
// Revision: 1.0
`default_nettype none

package fp_pkg;

  typedef enum logic [1:0] {
    OPC_ADD = 2'd0,
    OPC_SUB = 2'd1,
    OPC_MUL = 2'd2,
    OPC_DIV = 2'd3
  } opcode_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_INVALID   = 3'd1,
    ERR_DIV_ZERO  = 3'd2,
    ERR_OVERFLOW  = 3'd3,
    ERR_UNDERFLOW = 3'd4
  } o_err_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_AS_WAIT  = 3'd1,
    S_MUL_STB  = 3'd2,
    S_MUL_WAIT = 3'd3,
    S_DIV_GO   = 3'd4,
    S_DIV_WAIT = 3'd5,
    S_RESP     = 3'd6
  } seq_state_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

`default_nettype wire

// File: rtl/fp_seq_watchdog.sv
// fp_seq_watchdog: saturating latency counter with a fixed timeout compare.
// Revision: 1.0
`default_nettype none

module fp_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: accepts one FP request, drives the selected execution unit and
// returns its result; a watchdog aborts with qNaN if the unit never completes. Revision: 1.0
`default_nettype none

module fp_op_sequencer
  import fp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  opcode_t          req_opc,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             as_opcode,
  output logic [31:0]      as_a,
  output logic [31:0]      as_b,
  input  logic [31:0]      as_result,
  input  o_err_t           as_err,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_strb,
  input  logic             mul_ack,
  input  logic [31:0]      mul_result,
  input  logic             mul_done,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_start,
  input  logic             div_busy,
  input  logic [31:0]      div_result,
  input  o_err_t           div_err,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output opcode_t          rsp_opc,
  output o_err_t           rsp_err,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] rsp_cycles
);

  seq_state_t       state, state_next;
  opcode_t          op_opc;
  logic [31:0]      op_a, op_b;
  logic             seen_busy;
  logic             accept;
  logic             load_rsp;
  logic [31:0]      res_next;
  o_err_t           err_next;
  logic             tmo_next;
  logic [CNT_W-1:0] cyc_cnt;
  logic             wd_expired;
  logic             wd_enable;

  fp_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (wd_enable),
    .count  (cyc_cnt),
    .expired(wd_expired)
  );

  assign req_ready  = (state == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign wd_enable  = (state != S_IDLE) && (state != S_RESP);
  assign rsp_valid  = (state == S_RESP);
  assign mul_strb   = (state == S_MUL_STB);
  assign div_start  = (state == S_DIV_GO) && !div_busy;
  // The counter is frozen in RESP, so it still holds the value at RESP entry.
  assign rsp_cycles = cyc_cnt;

  assign as_opcode = op_opc[0];
  assign as_a      = op_a;
  assign as_b      = op_b;
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign div_a     = op_a;
  assign div_b     = op_b;

  always_comb begin
    state_next = state;
    load_rsp   = 1'b0;
    res_next   = FP_QNAN;
    err_next   = ERR_NONE;
    tmo_next   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          case (req_opc)
            OPC_MUL: state_next = S_MUL_STB;
            OPC_DIV: state_next = S_DIV_GO;
            default: state_next = S_AS_WAIT;
          endcase
        end
      end
      S_AS_WAIT: begin
        load_rsp   = 1'b1;
        res_next   = as_result;
        err_next   = as_err;
        state_next = S_RESP;
      end
      S_MUL_STB: begin
        if (mul_ack && mul_done) begin
          load_rsp   = 1'b1;
          res_next   = mul_result;
          state_next = S_RESP;
        end else if (mul_ack) begin
          state_next = S_MUL_WAIT;
        end else if (wd_expired) begin
          load_rsp   = 1'b1;
          tmo_next   = 1'b1;
          state_next = S_RESP;
        end
      end
      S_MUL_WAIT: begin
        if (mul_done) begin
          load_rsp   = 1'b1;
          res_next   = mul_result;
          state_next = S_RESP;
        end else if (wd_expired) begin
          load_rsp   = 1'b1;
          tmo_next   = 1'b1;
          state_next = S_RESP;
        end
      end
      S_DIV_GO: begin
        if (!div_busy) begin
          state_next = S_DIV_WAIT;
        end else if (wd_expired) begin
          load_rsp   = 1'b1;
          tmo_next   = 1'b1;
          state_next = S_RESP;
        end
      end
      S_DIV_WAIT: begin
        // Only a busy 1->0 edge marks completion of our own launch.
        if (seen_busy && !div_busy) begin
          load_rsp   = 1'b1;
          res_next   = div_result;
          err_next   = div_err;
          state_next = S_RESP;
        end else if (wd_expired) begin
          load_rsp   = 1'b1;
          tmo_next   = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_opc      <= OPC_ADD;
      op_a        <= '0;
      op_b        <= '0;
      seen_busy   <= 1'b0;
      rsp_result  <= '0;
      rsp_opc     <= OPC_ADD;
      rsp_err     <= ERR_NONE;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_opc <= req_opc;
        op_a   <= req_a;
        op_b   <= req_b;
      end
      if (state == S_DIV_GO) begin
        seen_busy <= 1'b0;
      end else if ((state == S_DIV_WAIT) && div_busy) begin
        seen_busy <= 1'b1;
      end
      if (load_rsp) begin
        rsp_result  <= res_next;
        rsp_opc     <= op_opc;
        rsp_err     <= err_next;
        rsp_timeout <= tmo_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_op_sequencer.sv
// tb_fp_op_sequencer: scoreboard bench with behavioural adder/multiplier/divider stubs.
// Revision: 1.0
`default_nettype none

module tb_fp_op_sequencer;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  opcode_t     req_opc = OPC_ADD;
  logic [31:0] req_a = '0, req_b = '0;
  logic        as_opcode;
  logic [31:0] as_a, as_b, as_result;
  o_err_t      as_err;
  logic [31:0] mul_a, mul_b, mul_result;
  logic        mul_strb, mul_ack, mul_done;
  logic [31:0] div_a, div_b, div_result;
  logic        div_start, div_busy;
  o_err_t      div_err;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  opcode_t     rsp_opc;
  o_err_t      rsp_err;
  logic        rsp_timeout;
  logic [6:0]  rsp_cycles;

  fp_op_sequencer #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opc(req_opc),
    .req_a(req_a), .req_b(req_b),
    .as_opcode(as_opcode), .as_a(as_a), .as_b(as_b),
    .as_result(as_result), .as_err(as_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_strb(mul_strb), .mul_ack(mul_ack),
    .mul_result(mul_result), .mul_done(mul_done),
    .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_busy(div_busy),
    .div_result(div_result), .div_err(div_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_opc(rsp_opc), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .rsp_cycles(rsp_cycles)
  );

  always #5 clk = ~clk;

  // Adder stub: combinational result chosen by the stimulus.
  logic [31:0] as_res_stub = '0;
  o_err_t      as_err_stub = ERR_NONE;
  assign as_result = as_res_stub;
  assign as_err    = as_err_stub;

  // Multiplier stub: ack on the 2nd strobe cycle, done 5 cycles after ack.
  int   strb_cyc = 0, strb_total = 0, done_cnt = 0;
  logic mul_hang = 1'b0;
  always @(posedge clk) begin
    strb_cyc <= mul_strb ? strb_cyc + 1 : 0;
    if (mul_strb) strb_total <= strb_total + 1;
    if (mul_strb && mul_ack) done_cnt <= 5;
    else if (done_cnt != 0) done_cnt <= done_cnt - 1;
  end
  assign mul_ack    = mul_strb && (strb_cyc == 1);
  assign mul_done   = !mul_hang && (done_cnt == 1);
  assign mul_result = mul_done ? 32'h4000_0000 : 32'hBAD0_BAD0;

  // Divider stub: busy for 26 cycles after a launch; garbage result while busy.
  int   div_cnt = 0, div_starts = 0;
  logic pre_busy = 1'b0;
  always @(posedge clk) begin
    if (div_start) div_starts <= div_starts + 1;
    if (div_start && !div_busy) div_cnt <= 26;
    else if (div_cnt != 0) div_cnt <= div_cnt - 1;
  end
  assign div_busy   = pre_busy || (div_cnt != 0);
  assign div_result = (div_cnt == 0) ? 32'h3F00_0000 : 32'hDEAD_BEEF;
  assign div_err    = (div_cnt == 0) ? ERR_OVERFLOW : ERR_INVALID;

  typedef struct {
    logic [31:0] res;
    opcode_t     opc;
    o_err_t      err;
    logic        tmo;
    logic [6:0]  cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Response monitor: compare each new response against the oldest expectation.
  logic rsp_seen = 1'b0;
  always @(negedge clk) begin
    if (rsp_valid && !rsp_seen) begin
      rsp_seen = 1'b1;
      if (sb.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_result",  rsp_result, e.res);
        check("rsp_opc",     32'(rsp_opc), 32'(e.opc));
        check("rsp_err",     32'(rsp_err), 32'(e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
        check("rsp_cycles",  32'(rsp_cycles), 32'(e.cyc));
      end
    end else if (!rsp_valid) begin
      rsp_seen = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge right after acceptance.
  task automatic send(input opcode_t opc, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n = 0;
    req_valid = 1'b1; req_opc = opc; req_a = a; req_b = b;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_accept_bound", 32'(req_ready), 32'd1);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrived", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int          s0, d0;
    logic        stable;
    logic [31:0] r_res;
    logic [6:0]  r_cyc;
    opcode_t     r_opc;

    repeat (3) @(negedge clk);
    check("rst_req_ready",  32'(req_ready), 32'd1);
    check("rst_rsp_valid",  32'(rsp_valid), 32'd0);
    check("rst_mul_strb",   32'(mul_strb), 32'd0);
    check("rst_div_start",  32'(div_start), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_cycles", 32'(rsp_cycles), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD 1.0 + 2.0
    as_res_stub = 32'h4040_0000; as_err_stub = ERR_NONE;
    send(OPC_ADD, 32'h3F80_0000, 32'h4000_0000, '{32'h4040_0000, OPC_ADD, ERR_NONE, 1'b0, 7'd1});
    check("add_as_a",      as_a, 32'h3F80_0000);
    check("add_as_b",      as_b, 32'h4000_0000);
    check("add_as_opcode", 32'(as_opcode), 32'd0);
    check("add_lat_c1",    32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("add_lat_c2",    32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("add_back_idle", 32'(req_ready), 32'd1);

    // SUB with an error code passed through
    as_res_stub = 32'hBF80_0000; as_err_stub = ERR_INVALID;
    send(OPC_SUB, 32'h3F80_0000, 32'h4000_0000, '{32'hBF80_0000, OPC_SUB, ERR_INVALID, 1'b0, 7'd1});
    check("sub_as_opcode", 32'(as_opcode), 32'd1);
    wait_rsp(10);
    @(negedge clk);
    as_err_stub = ERR_NONE;

    // MUL: ack on 2nd strobe cycle, done 5 cycles later
    s0 = strb_total;
    send(OPC_MUL, 32'h3F80_0000, 32'h4000_0000, '{32'h4000_0000, OPC_MUL, ERR_NONE, 1'b0, 7'd7});
    check("mul_a", mul_a, 32'h3F80_0000);
    check("mul_b", mul_b, 32'h4000_0000);
    wait_rsp(50);
    check("mul_strb_cycles", 32'(strb_total - s0), 32'd2);
    @(negedge clk);

    // DIV while the divider is still busy with earlier work
    d0 = div_starts;
    pre_busy = 1'b1;
    send(OPC_DIV, 32'h3F80_0000, 32'h4000_0000, '{32'h3F00_0000, OPC_DIV, ERR_OVERFLOW, 1'b0, 7'd30});
    check("div_a", div_a, 32'h3F80_0000);
    @(negedge clk);
    check("div_start_withheld", 32'(div_start), 32'd0);
    @(negedge clk);
    pre_busy = 1'b0;
    wait_rsp(100);
    check("div_start_pulses", 32'(div_starts - d0), 32'd1);
    @(negedge clk);

    // MUL that never completes: watchdog abort
    mul_hang = 1'b1;
    send(OPC_MUL, 32'h4040_0000, 32'h4000_0000, '{FP_QNAN, OPC_MUL, ERR_NONE, 1'b1, 7'd65});
    wait_rsp(200);
    check("tmo_strb_low", 32'(mul_strb), 32'd0);
    @(negedge clk);
    mul_hang = 1'b0;

    // Backpressure on an ADD response with a second request queued behind it
    rsp_ready = 1'b0;
    as_res_stub = 32'h40A0_0000;
    send(OPC_ADD, 32'h4000_0000, 32'h4040_0000, '{32'h40A0_0000, OPC_ADD, ERR_NONE, 1'b0, 7'd1});
    wait_rsp(10);
    r_res = rsp_result; r_cyc = rsp_cycles; r_opc = rsp_opc;
    as_res_stub = 32'h4000_0000;
    req_valid = 1'b1; req_opc = OPC_ADD; req_a = 32'h3F80_0000; req_b = 32'h3F80_0000;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== r_res || rsp_cycles !== r_cyc ||
          rsp_opc !== r_opc || rsp_timeout !== 1'b0 || req_ready !== 1'b0)
        stable = 1'b0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    sb.push_back('{32'h4000_0000, OPC_ADD, ERR_NONE, 1'b0, 7'd1});
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_no_same_cycle_accept", 32'(req_ready), 32'd1);
    check("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_second_accepted", 32'(req_ready), 32'd0);
    wait_rsp(10);
    @(negedge clk);

    // Reset while waiting on the divider
    send(OPC_DIV, 32'h4000_0000, 32'h3F80_0000, '{32'h4000_0000, OPC_DIV, ERR_NONE, 1'b0, 7'd0});
    repeat (5) @(negedge clk);
    check("rst_mid_busy", 32'(div_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_div_start", 32'(div_start), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);

    as_res_stub = 32'h4040_0000;
    send(OPC_ADD, 32'h3F80_0000, 32'h4000_0000, '{32'h4040_0000, OPC_ADD, ERR_NONE, 1'b0, 7'd1});
    wait_rsp(10);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_op_sequencer.md
Name: fp_op_sequencer

Overview:
- Issue/collect stage directly upstream of the FP execution units (add_sub_top, fp_multiplier, fdiv_newton).
- Accepts one FP request (opcode plus two single-precision operands) over a valid/ready handshake.
- Drives the protocol of the selected unit, captures its result and error code, and returns them over a valid/ready response channel.
- Single request in flight; a watchdog prevents a hung unit from locking the pipe.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent waiting on a unit before aborting with a timeout.
- CNT_W, 7: width of the latency counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_opc  in  2  opcode_t: ADD=0, SUB=1, MUL=2, DIV=3.
- req_a, req_b  in  32  IEEE-754 single-precision operands.
- as_opcode  out  1  add/sub select (req_opc[0]).
- as_a, as_b  out  32  add/sub operands; held stable while busy.
- as_result  in  32  add/sub result.
- as_err  in  o_err_t  add/sub error code.
- mul_a, mul_b  out  32  multiplier operands.
- mul_strb  out  1  multiplier operand strobe (drives both strb_A and strb_B).
- mul_ack  in  1  multiplier accepted operands (in_A_ack & in_B_ack).
- mul_result  in  32  multiplier product.
- mul_done  in  1  multiplier output valid (output_prod_stb).
- div_a, div_b  out  32  divider operands.
- div_start  out  1  divider launch pulse (gates fdiv).
- div_busy  in  1  divider busy.
- div_result  in  32  divider quotient.
- div_err  in  o_err_t  divider error code.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  result bits.
- rsp_opc  out  2  opcode that produced the result.
- rsp_err  out  o_err_t  unit error code; forced to ERR_NONE on timeout.
- rsp_timeout  out  1  unit failed to complete within TIMEOUT_CYCLES.
- rsp_cycles  out  CNT_W  cycles from acceptance to response valid.

Behaviour:
- Reset values: all outputs 0, except req_ready=1. State=IDLE, counter=0, seen_busy=0.
- Reset asserted mid-operation returns to IDLE on the next edge and drops all strobes. The in-flight request is lost.
- Request is accepted on req_valid & req_ready. req_ready=1 only in IDLE. On acceptance, opcode and operands are registered into all unit operand outputs, and cyc_cnt is cleared.
- cyc_cnt increments every cycle outside IDLE/RESP and saturates at all-ones.
- FSM states: IDLE, AS_WAIT, MUL_STB, MUL_WAIT, DIV_GO, DIV_WAIT, RESP.
- IDLE -> AS_WAIT (ADD/SUB), MUL_STB (MUL), or DIV_GO (DIV) on acceptance.
- AS_WAIT: exactly one cycle. Capture as_result/as_err, then go to RESP. Total latency: rsp_valid 2 cycles after the acceptance edge.
- MUL_STB: mul_strb=1 until mul_ack is sampled high, then MUL_WAIT with mul_strb=0.
- MUL_WAIT: on mul_done, capture mul_result and go to RESP. rsp_err=ERR_NONE for MUL.
- If mul_ack and mul_done are high in the same cycle while in MUL_STB, go directly to RESP with the captured result.
- DIV_GO: if div_busy=1 (divider still finishing prior work), wait. Otherwise pulse div_start for one cycle and go to DIV_WAIT with seen_busy=0.
- DIV_WAIT: set seen_busy on div_busy. Complete when seen_busy=1 and div_busy=0; capture div_result/div_err and go to RESP.
- Watchdog: in any waiting state, when cyc_cnt reaches TIMEOUT_CYCLES, go to RESP with rsp_timeout=1 and rsp_result=32'h7FC00000 (qNaN). Strobes deassert.
- RESP: rsp_valid=1; all rsp_* fields stay stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE. A new request is not accepted in that same cycle (req_ready rises the following cycle).
- rsp_cycles holds cyc_cnt as of the transition into RESP.

Decomposition:
- fp_pkg gains:
  - opcode_t enum with explicit 2-bit encoding.
  - seq_state_t enum.
  - FP_QNAN constant (32'h7FC00000).
  - o_err_t, reused as-is.
- One sub-module, fp_seq_watchdog: counter, saturation, and timeout compare, with clear/enable inputs.

Test Plan:
- ADD 1.0 (3F800000) + 2.0 (40000000), stub adder returns 40400000 -> rsp_valid 2 cycles after acceptance; rsp_result=40400000, rsp_opc=0, rsp_cycles=1.
- MUL 3F800000 x 40000000; stub asserts mul_ack after 2 cycles and mul_done 5 cycles later -> mul_strb high for exactly 2 cycles; rsp_result=40000000, rsp_timeout=0.
- DIV with div_busy already high for 3 cycles at acceptance -> div_start withheld until busy drops. Divider then stays busy 26 cycles -> one div_start pulse; result captured only after the busy 1->0 edge.
- MUL where stub never asserts mul_done -> after 64 cycles: rsp_timeout=1, rsp_result=7FC00000, rsp_err=ERR_NONE.
- Backpressure: rsp_ready held low 10 cycles after an ADD response -> rsp_* stable throughout, req_ready=0, and the second queued request is not accepted until the cycle after the handshake.
- rst asserted during DIV_WAIT -> next cycle: req_ready=1, div_start=0, rsp_valid=0. The following ADD completes normally.
